// File: rtl/fifo_w8_r16.sv
// Byte-in, word-out synchronous FIFO: packs byte pairs into 16-bit words.
// Older byte lands in dout[15:8]; registered flags track the post-update count.
module fifo_w8_r16 #(
    parameter  int DEPTH             = 1024,
    parameter  int PROG_FULL_THRESH  = 1000,
    parameter  int PROG_EMPTY_THRESH = 4,
    localparam int AW                = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [7:0]    din,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [15:0]   dout,
    output logic          full,
    output logic          almost_full,
    output logic          wr_ack,
    output logic          overflow,
    output logic          empty,
    output logic          almost_empty,
    output logic          valid,
    output logic          underflow,
    output logic [AW:0]   wr_data_count,
    output logic [AW-1:0] rd_data_count,
    output logic          prog_full,
    output logic          prog_empty
);

    localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_C   = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   PF_C   = (AW+1)'(PROG_FULL_THRESH);
    localparam logic [AW-1:0] PE_C   = AW'(PROG_EMPTY_THRESH);

    logic [7:0]    mem [DEPTH];

    logic [AW:0]   wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_d;
    logic [AW-1:0] rdc_d;
    logic [AW-1:0] ra0, ra1;
    logic          wr_acc, rd_acc;

    logic [15:0]   dout_q;
    logic          full_q, afull_q, wack_q, ovf_q;
    logic          empty_q, aempty_q, valid_q, udf_q;
    logic          pfull_q, pempty_q;
    logic [AW:0]   wrc_q;
    logic [AW-1:0] rdc_q;

    // Each side is judged against the flags registered for this cycle.
    always_comb begin
        wr_acc = wr_en & ~full_q;
        rd_acc = rd_en & ~empty_q;
        wp_d   = wp_q + (AW+1)'(wr_acc);
        rp_d   = rp_q + AW'(rd_acc);
        cnt_d  = wp_d - {rp_d, 1'b0};
        rdc_d  = cnt_d[AW:1];
        ra0    = {rp_q[AW-2:0], 1'b0};
        ra1    = {rp_q[AW-2:0], 1'b1};
    end

    always_ff @(posedge Clk) begin
        if (wr_acc) begin
            mem[wp_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wp_q     <= '0;
            rp_q     <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            wack_q   <= 1'b0;
            ovf_q    <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            valid_q  <= 1'b0;
            udf_q    <= 1'b0;
            pfull_q  <= 1'b0;
            pempty_q <= 1'b1;
            wrc_q    <= '0;
            rdc_q    <= '0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            if (rd_acc) begin
                dout_q <= {mem[ra0], mem[ra1]};
            end
            wack_q   <= wr_acc;
            ovf_q    <= wr_en & full_q;
            valid_q  <= rd_acc;
            udf_q    <= rd_en & empty_q;
            full_q   <= (cnt_d == FULL_C);
            afull_q  <= (cnt_d >= AF_C);
            empty_q  <= (cnt_d < (AW+1)'(2));
            aempty_q <= (cnt_d < (AW+1)'(4));
            pfull_q  <= (cnt_d >= PF_C);
            pempty_q <= (rdc_d <= PE_C);
            wrc_q    <= cnt_d;
            rdc_q    <= rdc_d;
        end
    end

    assign dout          = dout_q;
    assign full          = full_q;
    assign almost_full   = afull_q;
    assign wr_ack        = wack_q;
    assign overflow      = ovf_q;
    assign empty         = empty_q;
    assign almost_empty  = aempty_q;
    assign valid         = valid_q;
    assign underflow     = udf_q;
    assign wr_data_count = wrc_q;
    assign rd_data_count = rdc_q;
    assign prog_full     = pfull_q;
    assign prog_empty    = pempty_q;

endmodule
